// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with registered reads, write bypass, zero reg and pending scoreboard
// Storage is cleared by a one-register-per-cycle sweep after reset, so mem itself carries no reset.
module regfile_mp #(
    parameter int reg_width  = 5,
    parameter int reg_length = 2**reg_width,
    parameter int data_width = 32,
    parameter int read_ports = 2,
    parameter bit zero_reg   = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             ready,
    input  logic                             rd_en,
    input  logic [reg_width-1:0]             rd,
    input  logic [data_width-1:0]            rd_din,
    input  logic                             rsv_en,
    input  logic [reg_width-1:0]             rsv,
    input  logic [read_ports-1:0]            rs_en,
    input  logic [read_ports*reg_width-1:0]  rs_addr,
    output logic [read_ports*data_width-1:0] rs_dout,
    output logic [read_ports-1:0]            rs_pending
);

    typedef enum logic {CLEAR, READY} state_t;

    localparam logic [reg_width-1:0] last_idx = reg_width'(reg_length - 1);

    state_t                          state_q, state_d;
    logic [reg_width-1:0]            cnt_q, cnt_d;
    logic                            ready_q, ready_d;
    logic [reg_length-1:0]           pending_q, pending_d;
    logic [read_ports*data_width-1:0] rs_dout_q, rs_dout_d;
    logic [read_ports-1:0]           rs_pending_q, rs_pending_d;

    logic [data_width-1:0]           mem_q [reg_length];
    logic                            mem_we;
    logic [reg_width-1:0]            mem_waddr;
    logic [data_width-1:0]           mem_wdata;

    logic                            active;
    logic                            wr_drop;

    assign active  = (state_q == READY);
    assign wr_drop = zero_reg && (rd == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = rd;
        mem_wdata = rd_din;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == last_idx) begin
                state_d = READY;
                cnt_d   = '0;
            end
        end else begin
            mem_we = rd_en && !wr_drop;
        end
        ready_d = (state_d == READY);
    end

    // Reserve is applied after the write clear so a same-cycle reserve wins.
    always_comb begin
        pending_d = pending_q;
        if (active) begin
            if (rd_en) pending_d[rd] = 1'b0;
            if (rsv_en) pending_d[rsv] = 1'b1;
        end
        if (zero_reg) pending_d[0] = 1'b0;
    end

    always_comb begin
        rs_dout_d    = rs_dout_q;
        rs_pending_d = rs_pending_q;
        for (int i = 0; i < read_ports; i++) begin
            logic [reg_width-1:0] addr;
            addr = rs_addr[i*reg_width +: reg_width];
            if (active && rs_en[i]) begin
                if (zero_reg && (addr == '0))
                    rs_dout_d[i*data_width +: data_width] = '0;
                else if (rd_en && (rd == addr))
                    rs_dout_d[i*data_width +: data_width] = rd_din;
                else
                    rs_dout_d[i*data_width +: data_width] = mem_q[addr];
                rs_pending_d[i] = pending_d[addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= CLEAR;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            pending_q    <= '0;
            rs_dout_q    <= '0;
            rs_pending_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            pending_q    <= pending_d;
            rs_dout_q    <= rs_dout_d;
            rs_pending_q <= rs_pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign ready      = ready_q;
    assign rs_dout    = rs_dout_q;
    assign rs_pending = rs_pending_q;

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file for the copperv core with registered reads, write-to-read bypass, hardwired-zero register 0 and a per-register pending scoreboard. Contents are cleared by a post-reset sweep, one register per cycle, so storage needs no reset. Sits between decode (reads and reservations) and writeback (writes). Replaces the fixed two-read-port register file.

## Interface
- reg_width, 5: register address width
- reg_length, 2**reg_width: number of registers
- data_width, 32: register data width
- read_ports, 2: number of read ports (1..4)
- zero_reg, 1: 1 = register 0 reads 0, ignores writes, never pending
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- ready  out  1  high once the clear sweep is done
- rd_en  in  1  write enable
- rd  in  reg_width  write address
- rd_din  in  data_width  write data
- rsv_en  in  1  reserve enable: mark register pending
- rsv  in  reg_width  reserve address
- rs_en  in  read_ports  per-port read enable
- rs_addr  in  read_ports*reg_width  port i address at bits [i*reg_width +: reg_width]
- rs_dout  out  read_ports*data_width  port i registered data
- rs_pending  out  read_ports  port i registered pending flag

## Operation
- States: CLEAR, READY. Reset forces CLEAR and sweep counter cnt=0.
- CLEAR: each cycle write 0 to mem[cnt], cnt++. After writing reg_length-1, go to READY. ready=0 throughout. rd_en, rsv_en and rs_en are ignored.
- READY: ready=1. The block stays in READY until rst asserts.
- Write: rd_en in READY writes mem[rd]<=rd_din and clears pending[rd]. When zero_reg=1 and rd=0, the write is dropped.
- Reserve: rsv_en in READY sets pending[rsv]. rsv=0 has no effect when zero_reg=1.
- Reserve and write to the same register in one cycle: pending ends set (reserve wins). Data is still written.
- Read, port i, when rs_en[i] and READY:
  - rs_dout[i] <= 0 if zero_reg=1 and addr=0.
  - Otherwise rs_dout[i] <= rd_din if rd_en and rd==addr (bypass).
  - Otherwise rs_dout[i] <= mem[addr].
- rs_pending[i] <= next-state pending[addr], i.e. (pending[addr] & ~write-hit) | reserve-hit. It is always 0 for register 0 when zero_reg=1.
- rs_en[i]=0 or CLEAR: rs_dout[i] and rs_pending[i] hold their values.
- Ports are independent. Any number may read the same address in one cycle.
- pending is a reg_length-bit flop vector with async reset to 0. mem has no reset.

## Timing
- Reset values: ready=0, rs_dout=0 (all ports), rs_pending=0, pending=0, state=CLEAR, cnt=0.
- Sweep: ready rises on the clock edge exactly reg_length cycles after rst deasserts. The first edge after deassert clears reg 0.
- Read latency: 1 cycle. Address and enable are sampled at edge N; data is valid after edge N until the next enabled read.
- Write latency: data is visible to a read issued in the same cycle (bypass) and to any later read.
- Reset mid-operation (READY or CLEAR): outputs and pending clear immediately without waiting for clk. The sweep restarts from cnt=0.
- An enable asserted in the cycle ready rises has no effect. The first cycle with ready=1 at the sampling edge is serviced.

## Test plan
- Reset, release rst, count edges -> ready=1 after exactly 32 cycles. Reading any of r1..r31 then returns 0 and rs_pending=0.
- Write r5=0xDEADBEEF, next cycle read r5 on port 0 -> rs_dout[0]=0xDEADBEEF, rs_pending[0]=0.
- Write r7=0x12345678 while port 1 reads r7 in the same cycle -> rs_dout[1]=0x12345678 after that edge (bypass). Port 0 reading r7 one cycle earlier holds its old value.
- Write r0=0xFFFFFFFF, then read r0 on both ports -> 0, 0. rsv_en on r0 -> rs_pending=0.
- Scoreboard:
  - Reserve r3 -> read r3 shows pending=1.
  - Write r3=0xA5 with a concurrent read -> rs_dout=0xA5, pending=0.
  - Reserve and write r3 in the same cycle -> pending=1.
- Assert rst mid-stream after writing r9=0x55 -> ready=0 and rs_dout=0 immediately. After 32 cycles ready=1 and r9 reads 0.
